ldpc_dec_ctrl: RTL and testbench
================================

LDPC_DEC_CTRL -- requirements
Module: ldpc_dec_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 5, LLR width per bit.
REQ-002 SHALL have parameter NBITS, default 2304, codeword length (R*D).
REQ-003 SHALL have parameter ITER_W, default 6, iteration counter width.
REQ-004 SHALL have parameter DEF_MAX_ITER, default 32, reset value of the iteration limit.
REQ-005 SHALL have ports: clk input 1, the single clock.
REQ-006 SHALL have port rst input 1, synchronous active-low reset.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, and in_llr input NBITS*DATA_W for frame LLR input.
REQ-008 SHALL have ports cfg_max_iter input ITER_W and cfg_we input 1 for the runtime iteration limit.
REQ-009 SHALL have ports core_l output NBITS*DATA_W, core_en output 1 and core_clr output 1, which drive the decoder core.
REQ-010 SHALL have ports core_dec input NBITS (hard decisions) and core_syn_ok input 1 (all parity checks satisfied).
REQ-011 SHALL have ports out_valid output 1, out_ready input 1, out_res output NBITS, out_iter output ITER_W and out_conv output 1.

Function
REQ-012 SHALL buffer input frames in a two-slot ping-pong buffer, so the next frame can load while the current frame decodes.
REQ-013 SHALL assert in_ready while at least one slot is free; a frame SHALL transfer on in_valid&&in_ready.
REQ-014 SHALL use FSM states IDLE, CLEAR, RUN and HOLD.
REQ-015 IDLE->CLEAR SHALL occur when a slot is full; CLEAR SHALL last exactly 1 cycle, with core_clr=1, core_en=0 and core_l driven from the active slot.
REQ-016 CLEAR->RUN is unconditional. In RUN, core_en SHALL be 1 and the iteration counter SHALL increment by 1 each cycle, starting from 1 on the first RUN cycle.
REQ-017 RUN->HOLD SHALL occur on the first cycle where core_syn_ok=1 (out_conv=1) or iter==max_iter (out_conv=0). If both conditions hold together, out_conv SHALL be 1.
REQ-018 On the RUN->HOLD transition, out_res SHALL capture core_dec and out_iter SHALL capture the current iteration count; both SHALL stay stable while out_valid=1.
REQ-019 In HOLD, out_valid SHALL be 1 and core_en 0. On out_ready, the active slot SHALL be freed and the FSM SHALL go to CLEAR if the other slot is full, otherwise to IDLE.
REQ-020 An input write into the slot being freed in the same cycle SHALL NOT occur: in_ready SHALL reflect the slot status registered in the previous cycle.
REQ-021 A cfg_we write SHALL take effect only at the next CLEAR. A write of 0 SHALL be treated as 1.
REQ-022 out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-023 When rst=0 at a clk edge: FSM=IDLE, both slots empty, max_iter=DEF_MAX_ITER, and in_ready, out_valid, core_en, core_clr, out_res, out_iter and out_conv all 0.
REQ-024 A reset during RUN or HOLD SHALL discard all buffered frames; no out_valid SHALL follow the reset.

Configuration
REQ-025 With macro LDPC_DEC_STATS_EN defined, the module SHALL add outputs stat_frames (32 bits, frames completed) and stat_fail (32 bits, frames with out_conv=0). Both SHALL increment on each out_valid&&out_ready handshake, saturate at all-ones and clear on reset.
REQ-026 Without LDPC_DEC_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 The FSM state encoding and the ITER_W/DATA_W defaults SHALL reside in shared package ldpc_pkg.
REQ-028 The ping-pong storage SHALL be a sub-module ldpc_frame_buf, with write/read pointers and full flags; the FSM SHALL remain in ldpc_dec_ctrl.

Verification
REQ-029 Scenario: core_syn_ok held at 1, one frame -> CLEAR for 1 cycle, RUN for 1 cycle, out_valid rising on the 3rd cycle after acceptance, out_iter=1, out_conv=1.
REQ-030 Scenario: core_syn_ok held at 0, cfg_max_iter=5 -> exactly 5 core_en cycles, out_iter=5, out_conv=0.
REQ-031 Scenario: two back-to-back frames with out_ready=1 -> the second frame is accepted during the first decode, and the second CLEAR immediately follows the first HOLD.
REQ-032 Scenario: three frames, out_ready held at 0 -> in_ready=0 after the second frame is accepted, and out_res stays stable.
REQ-033 Scenario: rst=0 asserted mid-RUN -> all outputs 0 on the next cycle, and no stale result appears afterward.
REQ-034 Scenario: with LDPC_DEC_STATS_EN, 4 frames, 1 non-converging -> stat_frames=4, stat_fail=1.

Source files
------------

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared FSM encoding, width defaults and helpers
// for the LDPC decoder controller.
package ldpc_pkg;

  localparam int DATA_W_DEF = 5;
  localparam int ITER_W_DEF = 6;
  localparam int STAT_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } dec_state_t;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ldpc_frame_buf.sv
// ldpc_frame_buf: two-slot ping-pong frame store.
// Slots fill and drain in order, so it behaves as a depth-2 FIFO.
module ldpc_frame_buf #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_free,
  output logic         wr_ready,
  output logic [W-1:0] rd_data,
  output logic         rd_full,
  output logic         alt_full
);

  logic [W-1:0] mem [2];
  logic [1:0]   full_q;
  logic [1:0]   full_d;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         ready_q;

  always_comb begin
    full_d = full_q;
    if (wr_en)
      full_d[wr_ptr] = 1'b1;
    if (rd_free)
      full_d[rd_ptr] = 1'b0;
  end

  // ready is registered so a slot freed this cycle
  // only becomes writable on the next one
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      ready_q <= ~&full_d;
      if (wr_en)
        wr_ptr <= ~wr_ptr;
      if (rd_free)
        rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  assign wr_ready = ready_q;
  assign rd_data  = mem[rd_ptr];
  assign rd_full  = full_q[rd_ptr];
  assign alt_full = full_q[~rd_ptr];

endmodule

// File: rtl/ldpc_dec_ctrl.sv
// ldpc_dec_ctrl: frame buffering and iteration control for an LDPC core.
// Define LDPC_DEC_STATS_EN to add the stat_frames/stat_fail counters.
module ldpc_dec_ctrl
  import ldpc_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int NBITS        = 2304,
  parameter int ITER_W       = ITER_W_DEF,
  parameter int DEF_MAX_ITER = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NBITS*DATA_W-1:0] in_llr,
  input  logic [ITER_W-1:0]       cfg_max_iter,
  input  logic                    cfg_we,
  output logic [NBITS*DATA_W-1:0] core_l,
  output logic                    core_en,
  output logic                    core_clr,
  input  logic [NBITS-1:0]        core_dec,
  input  logic                    core_syn_ok,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NBITS-1:0]        out_res,
  output logic [ITER_W-1:0]       out_iter,
  output logic                    out_conv
`ifdef LDPC_DEC_STATS_EN
  ,
  output logic [STAT_W-1:0]       stat_frames,
  output logic [STAT_W-1:0]       stat_fail
`endif
);

  localparam int LW = NBITS * DATA_W;
  localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
  localparam logic [ITER_W-1:0] ITER_DEF = ITER_W'(DEF_MAX_ITER);

  dec_state_t        state_q;
  dec_state_t        state_d;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] max_q;
  logic [ITER_W-1:0] cfg_q;
  logic              wr_en;
  logic              rd_full;
  logic              alt_full;
  logic              hs;
  logic              done;

  assign wr_en = in_valid && in_ready;
  assign hs    = out_valid && out_ready;
  assign done  = core_syn_ok || (iter_q == max_q);

  ldpc_frame_buf #(
    .W (LW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (in_llr),
    .rd_free  (hs),
    .wr_ready (in_ready),
    .rd_data  (core_l),
    .rd_full  (rd_full),
    .alt_full (alt_full)
  );

  always_comb begin
    state_d  = state_q;
    core_en  = 1'b0;
    core_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_full)
          state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        core_clr = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        core_en = 1'b1;
        if (done)
          state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready)
          state_d = alt_full ? ST_CLEAR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // out_valid decodes the state register only
  assign out_valid = (state_q == ST_HOLD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      iter_q   <= '0;
      max_q    <= ITER_DEF;
      cfg_q    <= ITER_DEF;
      out_res  <= '0;
      out_iter <= '0;
      out_conv <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_we)
        cfg_q <= (cfg_max_iter == '0) ? ITER_ONE : cfg_max_iter;
      if (state_q == ST_CLEAR) begin
        max_q  <= cfg_q;
        iter_q <= ITER_ONE;
      end else if (state_q == ST_RUN && !done) begin
        iter_q <= iter_q + ITER_ONE;
      end
      if (state_q == ST_RUN && done) begin
        out_res  <= core_dec;
        out_iter <= iter_q;
        out_conv <= core_syn_ok;
      end
    end
  end

`ifdef LDPC_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_frames <= '0;
      stat_fail   <= '0;
    end else if (hs) begin
      stat_frames <= sat_inc(stat_frames);
      if (!out_conv)
        stat_fail <= sat_inc(stat_fail);
    end
  end
`endif

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// tb_ldpc_dec_ctrl: directed table plus multi-cycle sequences
// for ldpc_dec_ctrl with a small behavioural core model.
module tb_ldpc_dec_ctrl;

  localparam int DW  = 5;
  localparam int NB  = 8;
  localparam int IW  = 6;
  localparam int DEF = 6;
  localparam int LW  = NB * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_llr = '0;
  logic [IW-1:0] cfg_max_iter = '0;
  logic          cfg_we = 1'b0;
  logic [LW-1:0] core_l;
  logic          core_en;
  logic          core_clr;
  logic [NB-1:0] core_dec;
  logic          core_syn_ok;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NB-1:0] out_res;
  logic [IW-1:0] out_iter;
  logic          out_conv;
`ifdef LDPC_DEC_STATS_EN
  logic [31:0]   stat_frames;
  logic [31:0]   stat_fail;
`endif

  int checks = 0;
  int failures = 0;
  int syn_at = 0;
  int exp_frames = 0;
  int exp_fail = 0;
  logic [IW-1:0] en_cnt = '0;

  ldpc_dec_ctrl #(
    .DATA_W       (DW),
    .NBITS        (NB),
    .ITER_W       (IW),
    .DEF_MAX_ITER (DEF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_llr       (in_llr),
    .cfg_max_iter (cfg_max_iter),
    .cfg_we       (cfg_we),
    .core_l       (core_l),
    .core_en      (core_en),
    .core_clr     (core_clr),
    .core_dec     (core_dec),
    .core_syn_ok  (core_syn_ok),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_res      (out_res),
    .out_iter     (out_iter),
    .out_conv     (out_conv)
`ifdef LDPC_DEC_STATS_EN
    ,
    .stat_frames  (stat_frames),
    .stat_fail    (stat_fail)
`endif
  );

  always #5 clk = ~clk;

  // core model: decisions are LLR signs, flipped on odd iteration index
  always @(posedge clk) begin
    if (core_clr)
      en_cnt <= '0;
    else if (core_en)
      en_cnt <= en_cnt + 1'b1;
  end

  always_comb begin
    core_dec = '0;
    for (int i = 0; i < NB; i++)
      core_dec[i] = core_l[i*DW+DW-1] ^ en_cnt[0];
  end

  assign core_syn_ok = (syn_at != 0) && ((int'(en_cnt) + 1) >= syn_at);

  typedef struct {
    logic          we;
    logic [IW-1:0] max;
    int            syn;
    logic [LW-1:0] frame;
    int            it;
    logic          conv;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [NB-1:0] exp_res(logic [LW-1:0] f, int it);
    logic [NB-1:0] s;
    for (int i = 0; i < NB; i++)
      s[i] = f[i*DW+DW-1];
    if (it % 2 == 0)
      s = ~s;
    return s;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(string nm, logic [LW-1:0] f);
    int n;
    in_llr   = f;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    chk({nm, "_accept"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(string nm, logic [NB-1:0] er, int eit,
                          logic ec, output int lat, output int en);
    lat = 0;
    en  = 0;
    while (!out_valid && lat < 80) begin
      if (core_en)
        en++;
      tick();
      lat++;
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_res"}, out_res, er);
    chk({nm, "_iter"}, out_iter, eit);
    chk({nm, "_conv"}, out_conv, ec);
  endtask

  task automatic ack(logic c);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_frames++;
    if (!c)
      exp_fail++;
  endtask

  task automatic set_cfg(logic [IW-1:0] m);
    cfg_max_iter = m;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    int lat;
    int en;
    int bad;
    logic [NB-1:0] held;
    logic [LW-1:0] fa;
    logic [LW-1:0] fb;
    logic [LW-1:0] fc;

    tbl[0] = '{1'b0, 6'd0, 0, 40'hA53C960F71, DEF, 1'b0};
    tbl[1] = '{1'b1, 6'd5, 0, 40'h123456789A, 5, 1'b0};
    tbl[2] = '{1'b1, 6'd5, 1, 40'hFEDCBA9876, 1, 1'b1};
    tbl[3] = '{1'b1, 6'd5, 5, 40'h0F0F0F0F0F, 5, 1'b1};
    tbl[4] = '{1'b1, 6'd3, 2, 40'h8421084210, 2, 1'b1};
    tbl[5] = '{1'b1, 6'd0, 0, 40'hC3A5F00F5A, 1, 1'b0};
    tbl[6] = '{1'b1, 6'd7, 0, 40'h7E81ED1234, 7, 1'b0};

    tick();
    tick();
    chk("reset_outputs",
        {in_ready, out_valid, core_en, core_clr, out_conv, out_iter, out_res},
        '0);
    rst = 1'b1;
    tick();

    // table: single frame through an idle pipeline
    foreach (tbl[k]) begin
      syn_at = tbl[k].syn;
      if (tbl[k].we)
        set_cfg(tbl[k].max);
      send($sformatf("v%0d", k), tbl[k].frame);
      wait_out($sformatf("v%0d", k), exp_res(tbl[k].frame, tbl[k].it),
               tbl[k].it, tbl[k].conv, lat, en);
      chk($sformatf("v%0d_latency", k), lat, 2 + tbl[k].it);
      chk($sformatf("v%0d_en_cycles", k), en, tbl[k].it);
      ack(tbl[k].conv);
    end

    // back-to-back frames, cfg written mid-decode applies to frame B
    syn_at = 0;
    set_cfg(6'd4);
    fa = 40'h13579BDF02;
    fb = 40'hECA8642013;
    send("b2b_a", fa);
    send("b2b_b", fb);
    chk("b2b_b_during_a", out_valid, 0);
    tick();
    set_cfg(6'd2);
    wait_out("b2b_a", exp_res(fa, 4), 4, 1'b0, lat, en);
    out_ready = 1'b1;
    tick();
    exp_frames++;
    exp_fail++;
    chk("b2b_second_clear", core_clr, 1);
    wait_out("b2b_b", exp_res(fb, 2), 2, 1'b0, lat, en);
    tick();
    exp_frames++;
    exp_fail++;
    out_ready = 1'b0;

    // three frames with out_ready low: buffer fills, result holds
    syn_at = 1;
    fa = 40'h0102030405;
    fb = 40'hF1E2D3C4B5;
    fc = 40'h5A5A5AA5A5;
    send("stall_f1", fa);
    send("stall_f2", fb);
    chk("stall_full_ready", in_ready, 0);
    wait_out("stall_f1", exp_res(fa, 1), 1, 1'b1, lat, en);
    held = out_res;
    in_llr = fc;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready || !out_valid || out_res !== held)
        bad++;
      tick();
    end
    chk("stall_hold_stable", bad, 0);
    ack(1'b1);
    send("stall_f3", fc);
    wait_out("stall_f2", exp_res(fb, 1), 1, 1'b1, lat, en);
    ack(1'b1);
    wait_out("stall_f3", exp_res(fc, 1), 1, 1'b1, lat, en);
    ack(1'b1);

    // reset mid-RUN discards both buffered frames
    syn_at = 0;
    set_cfg(6'd10);
    send("rst_a", fa);
    send("rst_b", fb);
    bad = 0;
    while (!core_en && bad < 20) begin
      tick();
      bad++;
    end
    chk("rst_reached_run", core_en, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_run_outputs",
        {in_ready, out_valid, core_en, core_clr, out_conv, out_iter, out_res},
        '0);
    rst = 1'b1;
    exp_frames = 0;
    exp_fail = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid || core_en)
        bad++;
      tick();
    end
    chk("rst_no_stale", bad, 0);
    send("post_rst", fc);
    wait_out("post_rst", exp_res(fc, DEF), DEF, 1'b0, lat, en);
    chk("post_rst_en_cycles", en, DEF);
    ack(1'b0);

`ifdef LDPC_DEC_STATS_EN
    tick();
    chk("stat_frames", stat_frames, exp_frames);
    chk("stat_fail", stat_fail, exp_fail);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
